bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, word width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all flops rise on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_data, input, WIDTH bits: the parallel word to serialize.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is offered this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 The block SHALL have port out_bit, output, 1 bit: the serial data bit, MSB first; it drives the downstream div_by_3 input.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_bit carries a word bit this cycle.
REQ-009 The block SHALL have port out_first, output, 1 bit: out_bit is the MSB of a word; the downstream stage uses it to restart its remainder.
REQ-010 The block SHALL have port out_last, output, 1 bit: out_bit is the LSB of a word.

Function
REQ-011 A word SHALL be accepted on any rising edge where in_valid and in_ready are both 1.
REQ-012 The FSM SHALL have exactly two states, IDLE and SHIFT.
REQ-013 IDLE -> SHIFT SHALL occur on accept; SHIFT -> IDLE SHALL occur after the LSB cycle if no new word is accepted on that edge.
REQ-014 in_ready SHALL be 1 in IDLE, 1 in SHIFT only during the LSB cycle, and 0 otherwise; it is combinational from state and count only, never from in_valid.
REQ-015 The MSB SHALL appear on out_bit in the cycle immediately after the accept edge, so latency is 1 cycle.
REQ-016 Each word SHALL occupy exactly WIDTH consecutive cycles with out_valid=1.
REQ-017 out_first SHALL be 1 on bit index WIDTH-1, and out_last SHALL be 1 on bit index 0.
REQ-018 An accept during the LSB cycle SHALL start the next word's MSB on the next cycle, with zero gap.
REQ-019 In IDLE, outputs SHALL be out_valid=0, out_first=0, out_last=0 and out_bit=0.
REQ-020 in_data SHALL be captured into an internal shift register on accept; later changes to in_data SHALL NOT affect the word in flight.
REQ-021 The bit counter SHALL be $clog2(WIDTH) bits wide, load WIDTH-1 on accept, decrement each SHIFT cycle, and never wrap below 0.
REQ-022 out_bit, out_valid, out_first and out_last SHALL all be register outputs.

Reset
REQ-023 While rst=1, state SHALL be IDLE and out_bit, out_valid, out_first, out_last, the shift register and the counter SHALL all be 0; in_ready SHALL therefore read 1.
REQ-024 Reset asserted mid-word SHALL abort that word immediately (asynchronously); no remaining bits are emitted after reset releases.
REQ-025 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-026 Package bit_serializer_pkg SHALL hold the state enum (IDLE, SHIFT) and the constant DEFAULT_WIDTH = 8.
REQ-027 The block SHALL be a single module with no sub-modules; the shift register, counter and FSM are inline.

Verification
REQ-028 The bench SHALL cover single word: WIDTH=8, accept 8'hA5 -> out_bit 1,0,1,0,0,1,0,1 on 8 consecutive out_valid cycles, out_first on cycle 1, out_last on cycle 8, in_ready=0 on cycles 1..7.
REQ-029 The bench SHALL cover back-to-back: 8'hFF with in_valid held, then 8'h03 -> 16 contiguous out_valid cycles, bits 11111111 00000011, out_first on cycles 1 and 9.
REQ-030 The bench SHALL cover hold-off: in_valid=1 with 8'h3C from bit 2 of a word -> no accept until the LSB cycle, and the in-flight word is unaffected.
REQ-031 The bench SHALL cover mid-word reset: rst pulsed during bit 4 of 8'hF0 -> outputs 0 immediately, IDLE after release, and the next word 8'h81 emitted intact.
REQ-032 The bench SHALL cover the div_by_3 pair: feed 8'd9 then 8'd10, restarting the divider remainder on out_first -> divider remainder 2'b00 after word 1 and 2'b01 after word 2.
REQ-033 The bench SHALL cover WIDTH=2: accept 2'b10 -> out_first and out_last on adjacent cycles, and in_ready=1 during the LSB cycle.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// ============================================================================
//  Module   : bit_serializer_pkg
//  Brief    : Shared types and constants for the bit serializer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_serializer_pkg;

    // Two-state controller: waiting for a word, or shifting one out.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : bit_serializer_pkg

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
//  Module   : bit_serializer
//  Brief    : Parallel-to-serial converter, MSB first, with first/last flags
//             for a downstream bit-serial divide-by-3 stage. A new word can
//             be accepted during the LSB cycle so words stream with no gap.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             lsb_cycle;
    logic             accept;

    // cnt is the bit index currently presented on out_bit; index 0 is the LSB.
    assign lsb_cycle = (state == SHIFT) && (cnt == '0);
    // Ready depends on state and count only, never on in_valid.
    assign in_ready  = (state == IDLE) || lsb_cycle;
    assign accept    = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: stay in SHIFT across back-to-back words.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (lsb_cycle && !accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register, bit counter and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            cnt       <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            // The MSB goes straight to out_bit; shreg keeps the remaining
            // bits left-aligned so the next one is always shreg[WIDTH-1].
            shreg     <= {in_data[WIDTH-2:0], 1'b0};
            cnt       <= CNT_LOAD;
            out_bit   <= in_data[WIDTH-1];
            out_valid <= 1'b1;
            out_first <= 1'b1;
            out_last  <= 1'b0;
        end else if ((state == SHIFT) && !lsb_cycle) begin
            shreg     <= {shreg[WIDTH-2:0], 1'b0};
            cnt       <= cnt - CNT_ONE;
            out_bit   <= shreg[WIDTH-1];
            out_valid <= 1'b1;
            out_first <= 1'b0;
            out_last  <= (cnt == CNT_ONE);
        end else begin
            // LSB cycle without a follow-on word, or idle: outputs go quiet
            // and the counter rests at 0.
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule : bit_serializer

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// ============================================================================
//  Module   : tb_bit_serializer
//  Brief    : Self-checking bench for bit_serializer (WIDTH=8 and WIDTH=2).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serializer;

    // One table row per clock cycle: inputs applied in this cycle and the
    // outputs expected in this same cycle, packed as {ready,valid,bit,first,last}.
    typedef struct {
        string      name;
        logic       rst;
        logic       vld;
        logic [7:0] dat;
        logic [4:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, out_bit, out_valid, out_first, out_last;
    logic [1:0] in_data2 = '0;
    logic       in_valid2 = 1'b0;
    logic       in_ready2, out_bit2, out_valid2, out_first2, out_last2;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
        .out_first(out_first), .out_last(out_last)
    );

    bit_serializer #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .out_bit(out_bit2), .out_valid(out_valid2),
        .out_first(out_first2), .out_last(out_last2)
    );

    task automatic push(input string n, input logic r, input logic v,
                        input logic [7:0] d, input logic [4:0] e);
        vec_t t;
        t.name = n; t.rst = r; t.vld = v; t.dat = d; t.exp = e;
        vecs.push_back(t);
    endtask

    task automatic check(input string n, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: {rdy,vld,bit,first,last} got %b expected %b", n, act, exp);
        end
    endtask

    task automatic check_int(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    initial begin
        int rem;
        int sent;
        int done;
        int exp_rem[2];
        logic [7:0] words[2];

        // ---------------- table: {ready,valid,bit,first,last} ----------------
        push("reset",       1, 0, 8'h00, 5'b10000);
        // single word A5 (accept on first edge after reset release)
        push("a5_accept",   0, 1, 8'hA5, 5'b10000);
        push("a5_c1",       0, 0, 8'h00, 5'b01110);
        push("a5_c2",       0, 0, 8'h00, 5'b01000);
        push("a5_c3",       0, 0, 8'h00, 5'b01100);
        push("a5_c4",       0, 0, 8'h00, 5'b01000);
        push("a5_c5",       0, 0, 8'h00, 5'b01000);
        push("a5_c6",       0, 0, 8'h00, 5'b01100);
        push("a5_c7",       0, 0, 8'h00, 5'b01000);
        push("a5_c8",       0, 0, 8'h00, 5'b11101);
        push("a5_idle",     0, 0, 8'h00, 5'b10000);
        // back-to-back FF then 03
        push("b2b_accept",  0, 1, 8'hFF, 5'b10000);
        push("b2b_c1",      0, 1, 8'hFF, 5'b01110);
        push("b2b_c2",      0, 1, 8'hFF, 5'b01100);
        push("b2b_c3",      0, 1, 8'hFF, 5'b01100);
        push("b2b_c4",      0, 1, 8'hFF, 5'b01100);
        push("b2b_c5",      0, 1, 8'hFF, 5'b01100);
        push("b2b_c6",      0, 1, 8'hFF, 5'b01100);
        push("b2b_c7",      0, 1, 8'hFF, 5'b01100);
        push("b2b_c8",      0, 1, 8'h03, 5'b11101);
        push("b2b_c9",      0, 0, 8'h00, 5'b01010);
        push("b2b_c10",     0, 0, 8'h00, 5'b01000);
        push("b2b_c11",     0, 0, 8'h00, 5'b01000);
        push("b2b_c12",     0, 0, 8'h00, 5'b01000);
        push("b2b_c13",     0, 0, 8'h00, 5'b01000);
        push("b2b_c14",     0, 0, 8'h00, 5'b01000);
        push("b2b_c15",     0, 0, 8'h00, 5'b01100);
        push("b2b_c16",     0, 0, 8'h00, 5'b11101);
        push("b2b_idle",    0, 0, 8'h00, 5'b10000);
        // hold-off: 96 in flight, 3C offered from bit 2
        push("hold_accept", 0, 1, 8'h96, 5'b10000);
        push("hold_c1",     0, 0, 8'h96, 5'b01110);
        push("hold_c2",     0, 1, 8'h3C, 5'b01000);
        push("hold_c3",     0, 1, 8'h3C, 5'b01000);
        push("hold_c4",     0, 1, 8'h3C, 5'b01100);
        push("hold_c5",     0, 1, 8'h3C, 5'b01000);
        push("hold_c6",     0, 1, 8'h3C, 5'b01100);
        push("hold_c7",     0, 1, 8'h3C, 5'b01100);
        push("hold_c8",     0, 1, 8'h3C, 5'b11001);
        push("hold_c9",     0, 0, 8'h00, 5'b01010);
        push("hold_c10",    0, 0, 8'h00, 5'b01000);
        push("hold_c11",    0, 0, 8'h00, 5'b01100);
        push("hold_c12",    0, 0, 8'h00, 5'b01100);
        push("hold_c13",    0, 0, 8'h00, 5'b01100);
        push("hold_c14",    0, 0, 8'h00, 5'b01100);
        push("hold_c15",    0, 0, 8'h00, 5'b01000);
        push("hold_c16",    0, 0, 8'h00, 5'b11001);
        push("hold_idle",   0, 0, 8'h00, 5'b10000);
        // mid-word reset during bit 4 of F0, then 81 intact
        push("rst_accept",  0, 1, 8'hF0, 5'b10000);
        push("rst_c1",      0, 0, 8'h00, 5'b01110);
        push("rst_c2",      0, 0, 8'h00, 5'b01100);
        push("rst_c3",      0, 0, 8'h00, 5'b01100);
        push("rst_pulse",   1, 0, 8'h00, 5'b10000);
        push("rst_rel1",    0, 0, 8'h00, 5'b10000);
        push("rst_rel2",    0, 0, 8'h00, 5'b10000);
        push("w81_accept",  0, 1, 8'h81, 5'b10000);
        push("w81_c1",      0, 0, 8'h00, 5'b01110);
        push("w81_c2",      0, 0, 8'h00, 5'b01000);
        push("w81_c3",      0, 0, 8'h00, 5'b01000);
        push("w81_c4",      0, 0, 8'h00, 5'b01000);
        push("w81_c5",      0, 0, 8'h00, 5'b01000);
        push("w81_c6",      0, 0, 8'h00, 5'b01000);
        push("w81_c7",      0, 0, 8'h00, 5'b01000);
        push("w81_c8",      0, 0, 8'h00, 5'b11101);
        push("w81_idle",    0, 0, 8'h00, 5'b10000);

        // Apply each row just after the falling edge, check 1 ns later.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst      = vecs[i].rst;
            in_valid = vecs[i].vld;
            in_data  = vecs[i].dat;
            #1;
            check(vecs[i].name, {in_ready, out_valid, out_bit, out_first, out_last},
                  vecs[i].exp);
        end

        // ---------------- div_by_3 pair: 9 then 10, streamed ----------------
        words[0] = 8'd9;  words[1] = 8'd10;
        exp_rem[0] = 0;   exp_rem[1] = 1;
        rem = 0; sent = 0; done = 0;
        for (int cyc = 0; cyc < 40 && done < 2; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                rem = out_first ? int'(out_bit) : (rem * 2 + int'(out_bit)) % 3;
                if (out_last) begin
                    check_int($sformatf("div3_word%0d", done), rem, exp_rem[done]);
                    done++;
                end
            end
            if (sent < 2 && in_ready) begin
                in_valid = 1'b1;
                in_data  = words[sent];
                sent++;
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
        end
        check_int("div3_words_seen", done, 2);
        in_valid = 1'b0;

        // ---------------- WIDTH=2: accept 2'b10 ----------------
        @(negedge clk);
        in_valid2 = 1'b1; in_data2 = 2'b10;
        #1;
        check("w2_accept", {in_ready2, out_valid2, out_bit2, out_first2, out_last2}, 5'b10000);
        @(negedge clk);
        in_valid2 = 1'b0; in_data2 = 2'b00;
        #1;
        check("w2_msb", {in_ready2, out_valid2, out_bit2, out_first2, out_last2}, 5'b01110);
        @(negedge clk);
        #1;
        check("w2_lsb", {in_ready2, out_valid2, out_bit2, out_first2, out_last2}, 5'b11001);
        @(negedge clk);
        #1;
        check("w2_idle", {in_ready2, out_valid2, out_bit2, out_first2, out_last2}, 5'b10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bit_serializer

`default_nettype wire
